// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: defaults, state encoding
// and the bubble instruction presented to decode when nothing is buffered.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST  = 32'h0000_0000;

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two.
// Flush and reset take priority over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only real entries; a push into a full FIFO is allowed when the head leaves.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Status and head.
  always_comb begin
    head  = mem[rd_ptr];
    full  = (count == (AW+1)'(DEPTH));
    empty = (count == '0);
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, credit-limited memory requests, in-order buffering.
// Optional FETCH_PERF_EN adds delivered-instruction and bubble counters.
module fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            D_stall,
  input  logic            E_redirect,
  input  logic [XLEN-1:0] E_redirect_pc,
  output logic [XLEN-1:0] F_inst,
  output logic [XLEN-1:0] F_pc,
  output logic            F_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     F_perf_fetched,
  output logic [31:0]     F_perf_bubbles
`endif
);

  localparam int            CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(BUF_DEPTH);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [XLEN-1:0]    pc;
  logic [CW-1:0]      drop;
  logic [CW-1:0]      drop_next;
  logic [CW:0]        drop_sum;
  logic [CW:0]        occupancy;
  logic               handshake;
  logic               rsp_keep;
  logic               rsp_drop;
  logic               inst_pop;
  logic               inst_push;

  logic [XLEN-1:0]    tag_head;
  logic               tag_full;
  logic               tag_empty;
  logic [CW-1:0]      tag_count;
  logic [2*XLEN-1:0]  inst_head;
  logic               inst_full;
  logic               inst_empty;
  logic [CW-1:0]      inst_count;

  // Tag FIFO occupancy doubles as the count of live (non-stale) outstanding requests.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clk(clk), .rst(rst), .push(handshake), .push_data(pc), .pop(rsp_keep),
    .flush(E_redirect), .head(tag_head), .full(tag_full), .empty(tag_empty),
    .count(tag_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(BUF_DEPTH)) u_inst_fifo (
    .clk(clk), .rst(rst), .push(inst_push), .push_data({tag_head, imem_rsp_data}),
    .pop(inst_pop), .flush(E_redirect), .head(inst_head), .full(inst_full),
    .empty(inst_empty), .count(inst_count)
  );

  // Response routing, pop and redirect drop bookkeeping.
  always_comb begin
    handshake = imem_req_valid & imem_req_ready;
    rsp_drop  = imem_rsp_valid & (drop != '0);
    rsp_keep  = imem_rsp_valid & (drop == '0) & ~tag_empty;
    inst_pop  = ~inst_empty & ~D_stall & ~E_redirect;
    inst_push = rsp_keep & ~E_redirect & (~inst_full | inst_pop);
    occupancy = {1'b0, inst_count} + {1'b0, tag_count} - {{CW{1'b0}}, inst_pop};
    drop_sum  = {1'b0, drop} + {1'b0, tag_count} + {{CW{1'b0}}, handshake}
              - {{CW{1'b0}}, rsp_keep} - {{CW{1'b0}}, rsp_drop};
    if (E_redirect) begin
      if (drop_sum > DEPTH_W) begin
        drop_next = DEPTH_W[CW-1:0];
      end else begin
        drop_next = drop_sum[CW-1:0];
      end
    end else begin
      drop_next = drop - {{(CW-1){1'b0}}, rsp_drop};
    end
  end

  // State, pc and drop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_RUN;
      pc    <= RESET_PC;
      drop  <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (E_redirect) begin
        pc <= E_redirect_pc;
      end else if (handshake) begin
        pc <= pc + XLEN'(4);
      end
    end
  end

  // Next state: drain leaves one cycle after the drop count has reached zero.
  always_comb begin
    state_next = state;
    if (E_redirect) begin
      state_next = (drop_next != '0) ? FS_DRAIN : FS_RUN;
    end else begin
      case (state)
        FS_RUN:   state_next = FS_RUN;
        FS_DRAIN: state_next = (drop == '0) ? FS_RUN : FS_DRAIN;
        default:  state_next = FS_RUN;
      endcase
    end
  end

  // Outputs; a slot freed by this cycle's pop already counts as credit.
  always_comb begin
    imem_req_addr  = pc;
    imem_req_valid = ~rst & (state == FS_RUN) & ~E_redirect & ~tag_full
                   & (occupancy < DEPTH_W);
    F_valid        = ~inst_empty;
    if (inst_empty) begin
      F_inst = XLEN'(BUBBLE_INST);
      F_pc   = '0;
    end else begin
      F_inst = inst_head[XLEN-1:0];
      F_pc   = inst_head[2*XLEN-1:XLEN];
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and empty-cycle counters; they survive redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_perf_fetched <= 32'd0;
      F_perf_bubbles <= 32'd0;
    end else begin
      if (inst_pop)   F_perf_fetched <= F_perf_fetched + 32'd1;
      if (inst_empty) F_perf_bubbles <= F_perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-bench memory model plus an expected-PC scoreboard.
module tb_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        D_stall, E_redirect, F_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, E_redirect_pc, F_inst, F_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] F_perf_fetched, F_perf_bubbles;
`endif

  fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .D_stall(D_stall), .E_redirect(E_redirect),
    .E_redirect_pc(E_redirect_pc), .F_inst(F_inst), .F_pc(F_pc), .F_valid(F_valid)
`ifdef FETCH_PERF_EN
    , .F_perf_fetched(F_perf_fetched), .F_perf_bubbles(F_perf_bubbles)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] sb_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 1, delivered = 0;
  int          fetched_exp = 0, bubbles_exp = 0;
  logic        s_req, s_fv;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  // One clock cycle: drive memory response, sample outputs, score deliveries.
  task automatic step();
    logic [31:0] exp_pc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~mem_q[0].addr;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0000_0000;
    end
    #1;
    s_req  = imem_req_valid;
    s_addr = imem_req_addr;
    s_fv   = F_valid;
    s_pc   = F_pc;
    s_inst = F_inst;
    if (rst) begin
      fetched_exp = 0;
      bubbles_exp = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) mem_q.push_back('{imem_req_addr, cyc + lat});
      if (!F_valid) bubbles_exp++;
      if (F_valid && !D_stall && !E_redirect) begin
        delivered++;
        fetched_exp++;
        checks++;
        assert (sb_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%h expected=none", F_pc);
        end
        if (sb_q.size() != 0) begin
          exp_pc = sb_q.pop_front();
          chk("sb_pc", F_pc, exp_pc);
          chk("sb_inst", F_inst, ~exp_pc);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int n, d0;
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    D_stall = 1'b0; E_redirect = 1'b0; E_redirect_pc = 32'h0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_req_valid", {31'd0, s_req}, 32'd0);
    chk("rst_f_valid", {31'd0, s_fv}, 32'd0);
    chk("rst_f_inst", s_inst, 32'd0);
    chk("rst_f_pc", s_pc, 32'd0);

    // Back-to-back fetch with 1-cycle memory.
    rst = 1'b0;
    push_seq(32'h0, 16);
    step();
    chk("t1_req_c1", {31'd0, s_req}, 32'd1);
    chk("t1_addr_c1", s_addr, 32'h0);
    chk("t1_fv_c1", {31'd0, s_fv}, 32'd0);
    step();
    chk("t1_req_c2", {31'd0, s_req}, 32'd1);
    chk("t1_addr_c2", s_addr, 32'h4);
    chk("t1_fv_c2", {31'd0, s_fv}, 32'd0);
    step();
    chk("t1_req_c3", {31'd0, s_req}, 32'd1);
    chk("t1_addr_c3", s_addr, 32'h8);
    chk("t1_fv_c3", {31'd0, s_fv}, 32'd1);
    chk("t1_pc_c3", s_pc, 32'h0);
    repeat (2) step();

    // Decode stall fills the buffer and stops requests.
    D_stall = 1'b1;
    repeat (5) step();
    chk("t2_req_stalled", {31'd0, s_req}, 32'd0);
    chk("t2_fv_stalled", {31'd0, s_fv}, 32'd1);
    D_stall = 1'b0;
    repeat (6) step();

    // Latency 3, redirect to 0x100 with requests in flight.
    lat = 3;
    repeat (8) step();
    E_redirect = 1'b1; E_redirect_pc = 32'h100;
    step();
    chk("t3_req_in_redirect", {31'd0, s_req}, 32'd0);
    E_redirect = 1'b0;
    sb_q.delete();
    push_seq(32'h100, 32);
    n = 0;
    do begin step(); n++; end while (!s_req && n < 20);
    chk("t3_first_req_seen", {31'd0, s_req}, 32'd1);
    chk("t3_first_req_addr", s_addr, 32'h100);
    d0 = delivered;
    repeat (12) step();
    chk("t3_progress", {31'd0, (delivered - d0) >= 3}, 32'd1);

    // Redirect colliding with a would-be handshake, a response and a pop.
    lat = 1;
    repeat (12) step();
    E_redirect = 1'b1; E_redirect_pc = 32'h200;
    step();
    chk("t4_req_in_redirect", {31'd0, s_req}, 32'd0);
    E_redirect = 1'b0;
    sb_q.delete();
    push_seq(32'h200, 32);
    step();
    chk("t4_req_after", {31'd0, s_req}, 32'd1);
    chk("t4_addr_after", s_addr, 32'h200);
    d0 = delivered;
    repeat (8) step();
    chk("t4_progress", {31'd0, (delivered - d0) >= 5}, 32'd1);

    // Reset during drain while stale responses are still returning.
    lat = 3;
    repeat (6) step();
    E_redirect = 1'b1; E_redirect_pc = 32'h300;
    step();
    E_redirect = 1'b0;
    rst = 1'b1;
    repeat (4) step();
    chk("t5_rst_req_valid", {31'd0, s_req}, 32'd0);
    chk("t5_rst_f_valid", {31'd0, s_fv}, 32'd0);
    chk("t5_rst_f_inst", s_inst, 32'd0);
    chk("t5_rst_f_pc", s_pc, 32'd0);
    mem_q.delete();
    sb_q.delete();
    push_seq(32'h0, 32);
    rst = 1'b0; lat = 1;
    step();
    chk("t5_req_after_rst", {31'd0, s_req}, 32'd1);
    chk("t5_addr_after_rst", s_addr, 32'h0);
    repeat (3) step();
    D_stall = 1'b1;
    repeat (2) step();
    D_stall = 1'b0;
    repeat (8) step();

`ifdef FETCH_PERF_EN
    chk("perf_fetched", F_perf_fetched, 32'(fetched_exp));
    chk("perf_bubbles", F_perf_bubbles, 32'(bubbles_exp));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
